sat_adder_tree_pipelined: RTL and testbench
===========================================

Name: sat_adder_tree_pipelined

Overview:
- Parametrised N-input saturating two's-complement adder with a pipelined tree and an optional multi-beat accumulate mode.
- Generalises the decoder's fixed 3-input saturating adder to N lanes, full-precision internal width, and valid-tagged pipeline stages.
- Used for variable-node sums in the LDPC decoder. Accumulate mode sums messages that arrive serially over several beats.

Parameters:
W, 10, lane and output width (two's complement)
N, 4, number of input lanes (2..16)
ACC_BITS, 4, extra accumulator headroom bits (supports groups up to 2^ACC_BITS beats without internal clamp)
LEVELS, clog2(N), derived; tree pipeline depth
FW, W+LEVELS+ACC_BITS, derived; accumulator width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_data  in  N*W  lane i at [i*W +: W], two's complement
in_valid  in  1  beat present this cycle
in_last  in  1  accumulate mode: final beat of group; ignored when acc_en=0
acc_en  in  1  sampled with in_valid; 1 = beat belongs to an accumulation group
out_sum  out  W  saturated result
out_valid  out  1  one-cycle pulse per result
out_sat  out  1  result was clamped (any clamp in this result's path)

Behaviour:
- Reset (rst=0, async): all tree registers, tags, accumulator, group-open flag, out_sum, out_valid and out_sat are cleared to 0 immediately. In-flight beats are discarded.
- No backpressure. A beat can be accepted every cycle, and throughput is one result per cycle.
- Tree structure:
  - Sign-extend lanes to W+LEVELS bits.
  - Level k adds adjacent pairs; an odd leftover operand passes through unchanged.
  - Each level is registered.
  - valid, last and acc_en travel in tag registers alongside the data.
  - The tree never overflows.
- Final stage (one register). It acts when the tree-output tag valid=1.
  - acc_en=0: out_sum = sat_W(tree_sum). Any open accumulator group is left untouched.
  - acc_en=1, group not open: acc = sext(tree_sum); group opens.
  - acc_en=1, group open: acc = sat_FW(acc + tree_sum).
  - acc_en=1, last=1: out_sum = sat_W(the updated acc value above), out_valid=1, group closes, acc cleared.
  - acc_en=1, last=0: no output is produced.
- Latency:
  - Non-accumulate beat: LEVELS+1 cycles from in_valid to out_valid.
  - Accumulate group: LEVELS+1 cycles after its last beat.
- Saturation:
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1], giving 10'h1FF / 10'h200 for W=10.
  - sat_FW clamps the accumulator the same way at FW bits.
  - out_sat=1 if either clamp fired for this result; it is sticky across a group's beats and cleared when the group closes.
- out_sum and out_sat hold their last values while out_valid=0.
- A single-beat group (acc_en=1, in_last=1) behaves identically to a non-accumulate beat.
- Interleaving: a non-accumulate beat inside an open group produces its own output. The group continues with the next acc_en=1 beat.
- Reset during an open group: the group is abandoned. The first acc_en=1 beat after reset opens a new group starting from 0.

Test Plan:
- W=10, N=4, all lanes +100, acc_en=0 -> out_sum=400, out_valid 3 cycles later, out_sat=0.
- All lanes +511 -> out_sum=511, out_sat=1. All lanes -512 -> out_sum=-512, out_sat=1.
- Lanes {511,511,-512,-512} -> out_sum=-2, out_sat=0 (proves full-precision tree).
- Accumulate group:
  - Three beats of all lanes +50, in_last on beat 3 -> single output 511, out_sat=1.
  - Beats {+100 lanes, -100 lanes} -> 0, out_sat=0.
- Eight consecutive acc_en=0 beats with distinct sums -> eight consecutive out_valid cycles in order. A non-accumulate beat injected mid-group leaves the group result correct.
- rst pulsed low mid-group with beats in flight -> out_valid=0 immediately and no stale output. A following 2-beat group of +10 lanes -> 80.

Source files
------------

// File: rtl/sat_adder_tree_pipelined.sv
// N-input saturating two's-complement adder.
// The lanes are summed by a registered binary tree that runs at full precision.
// A final registered stage either saturates the tree sum to W bits, or folds
// it into a multi-beat accumulator and emits one saturated result per group.
// valid, last and acc_en travel through the tree in tag registers beside the data.
module sat_adder_tree_pipelined #(
    parameter int W        = 10,
    parameter int N        = 4,
    parameter int ACC_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             acc_en,
    output logic [W-1:0]     out_sum,
    output logic             out_valid,
    output logic             out_sat
);

    // Tree depth. TW is wide enough that no tree level can overflow.
    localparam int LEVELS = (N > 1) ? $clog2(N) : 1;
    localparam int TW     = W + LEVELS;
    localparam int FW     = W + LEVELS + ACC_BITS;

    // Number of live operands at tree level k (level 0 = input lanes).
    function automatic int lvl_cnt(input int k);
        int c;
        c = N;
        for (int i = 0; i < LEVELS; i++) begin
            if (i < k) begin
                c = (c + 1) / 2;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Clamp an FW-bit value to W bits; MSB of the result flags a clamp.
    // The value fits when bits FW-1..W-1 are all equal.
    function automatic logic [W:0] sat_w(input logic [FW-1:0] v);
        logic [W:0] r;
        if ((&v[FW-1:W-1]) || !(|v[FW-1:W-1])) begin
            r = {1'b0, v[W-1:0]};
        end else if (v[FW-1]) begin
            r = {1'b1, 1'b1, {(W-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

    // Clamp an (FW+1)-bit sum back to FW bits; MSB of the result flags a clamp.
    function automatic logic [FW:0] sat_fw(input logic [FW:0] v);
        logic [FW:0] r;
        if (v[FW] == v[FW-1]) begin
            r = {1'b0, v[FW-1:0]};
        end else if (v[FW]) begin
            r = {1'b1, 1'b1, {(FW-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(FW-1){1'b1}}};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Tree
    // ------------------------------------------------------------------
    logic [TW-1:0]     stage_s [0:LEVELS][0:N-1];
    logic [TW-1:0]     nxt_s   [1:LEVELS][0:N-1];
    logic [TW-1:0]     tree_r  [1:LEVELS][0:N-1];
    logic [LEVELS-1:0] vld_tag_r;
    logic [LEVELS-1:0] last_tag_r;
    logic [LEVELS-1:0] acc_tag_r;

    // Present every tree level as one array: sign-extended lanes, then the level registers.
    always_comb begin
        for (int k = 0; k <= LEVELS; k++) begin
            for (int j = 0; j < N; j++) begin
                stage_s[k][j] = {TW{1'b0}};
            end
        end
        for (int j = 0; j < N; j++) begin
            stage_s[0][j] = {{LEVELS{in_data[j*W+W-1]}}, in_data[j*W +: W]};
        end
        for (int k = 1; k <= LEVELS; k++) begin
            for (int j = 0; j < N; j++) begin
                stage_s[k][j] = tree_r[k][j];
            end
        end
    end

    // Pairwise adds for each level; an odd leftover operand passes through unchanged.
    always_comb begin
        int prev_cnt;
        int ia;
        int ib;
        prev_cnt = 0;
        ia       = 0;
        ib       = 0;
        for (int k = 1; k <= LEVELS; k++) begin
            for (int j = 0; j < N; j++) begin
                prev_cnt = lvl_cnt(k - 1);
                ia = (2 * j < N)     ? 2 * j     : N - 1;
                ib = (2 * j + 1 < N) ? 2 * j + 1 : N - 1;
                if (2 * j + 1 < prev_cnt) begin
                    nxt_s[k][j] = stage_s[k-1][ia] + stage_s[k-1][ib];
                end else if (2 * j < prev_cnt) begin
                    nxt_s[k][j] = stage_s[k-1][ia];
                end else begin
                    nxt_s[k][j] = {TW{1'b0}};
                end
            end
        end
    end

    // Register each tree level and shift the beat tags alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= LEVELS; k++) begin
                for (int j = 0; j < N; j++) begin
                    tree_r[k][j] <= {TW{1'b0}};
                end
            end
            vld_tag_r  <= {LEVELS{1'b0}};
            last_tag_r <= {LEVELS{1'b0}};
            acc_tag_r  <= {LEVELS{1'b0}};
        end else begin
            for (int k = 1; k <= LEVELS; k++) begin
                for (int j = 0; j < N; j++) begin
                    tree_r[k][j] <= nxt_s[k][j];
                end
            end
            vld_tag_r[0]  <= in_valid;
            last_tag_r[0] <= in_last;
            acc_tag_r[0]  <= acc_en;
            for (int k = 1; k < LEVELS; k++) begin
                vld_tag_r[k]  <= vld_tag_r[k-1];
                last_tag_r[k] <= last_tag_r[k-1];
                acc_tag_r[k]  <= acc_tag_r[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Final stage: saturate or accumulate
    // ------------------------------------------------------------------
    logic          t_vld_s;
    logic          t_last_s;
    logic          t_acc_s;
    logic [TW-1:0] tree_sum_s;
    logic [FW-1:0] tree_ext_s;
    logic [FW:0]   acc_pack_s;
    logic [FW-1:0] acc_new_s;
    logic          acc_fire_s;
    logic [FW-1:0] w_src_s;
    logic [W:0]    w_pack_s;

    logic [FW-1:0] acc_r;
    logic          open_r;
    logic          sticky_r;
    logic [W-1:0]  out_sum_r;
    logic          out_valid_r;
    logic          out_sat_r;

    // Next accumulator value and the W-bit clamp of whichever value this beat would emit.
    always_comb begin
        t_vld_s    = vld_tag_r[LEVELS-1];
        t_last_s   = last_tag_r[LEVELS-1];
        t_acc_s    = acc_tag_r[LEVELS-1];
        tree_sum_s = stage_s[LEVELS][0];
        tree_ext_s = {{ACC_BITS{tree_sum_s[TW-1]}}, tree_sum_s};
        acc_pack_s = sat_fw({acc_r[FW-1], acc_r} + {tree_ext_s[FW-1], tree_ext_s});
        if (open_r) begin
            acc_new_s  = acc_pack_s[FW-1:0];
            acc_fire_s = acc_pack_s[FW];
        end else begin
            // First beat of a group loads the tree sum directly.
            acc_new_s  = tree_ext_s;
            acc_fire_s = 1'b0;
        end
        if (t_acc_s) begin
            w_src_s = acc_new_s;
        end else begin
            w_src_s = tree_ext_s;
        end
        w_pack_s = sat_w(w_src_s);
    end

    // Result register and accumulator/group state; non-accumulate beats leave an open group untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= {FW{1'b0}};
            open_r      <= 1'b0;
            sticky_r    <= 1'b0;
            out_sum_r   <= {W{1'b0}};
            out_valid_r <= 1'b0;
            out_sat_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (t_vld_s) begin
                if (!t_acc_s) begin
                    out_sum_r   <= w_pack_s[W-1:0];
                    out_sat_r   <= w_pack_s[W];
                    out_valid_r <= 1'b1;
                end else if (t_last_s) begin
                    out_sum_r   <= w_pack_s[W-1:0];
                    out_sat_r   <= sticky_r | acc_fire_s | w_pack_s[W];
                    out_valid_r <= 1'b1;
                    acc_r       <= {FW{1'b0}};
                    open_r      <= 1'b0;
                    sticky_r    <= 1'b0;
                end else begin
                    acc_r    <= acc_new_s;
                    open_r   <= 1'b1;
                    sticky_r <= sticky_r | acc_fire_s;
                end
            end
        end
    end

    assign out_sum   = out_sum_r;
    assign out_valid = out_valid_r;
    assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_sat_adder_tree_pipelined.sv
// Directed bench for sat_adder_tree_pipelined (W=10, N=4, LEVELS=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sat_adder_tree_pipelined;

    localparam int W = 10;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic           in_valid;
    logic           in_last;
    logic           acc_en;
    logic [W-1:0]   out_sum;
    logic           out_valid;
    logic           out_sat;

    int pass_cnt = 0;
    int total_cnt = 0;

    sat_adder_tree_pipelined #(.W(W), .N(N), .ACC_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .acc_en    (acc_en),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] all4(input logic [W-1:0] v);
        return {v, v, v, v};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N*W-1:0] d, input logic v, input logic l, input logic a);
        in_data  = d;
        in_valid = v;
        in_last  = l;
        acc_en   = a;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        in_data  = {(N*W){1'b0}};
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_en   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 16'(out_valid), 16'h0000);
        chk("rst_sum",   16'(out_sum),   16'h0000);
        chk("rst_sat",   16'(out_sat),   16'h0000);
        rst = 1'b1;
        @(negedge clk);

        // +100 on all lanes: 400, three cycles after the beat.
        drive(all4(10'd100), 1'b1, 1'b0, 1'b0);
        idle_inputs();
        chk("lat_c1_valid", 16'(out_valid), 16'h0000);
        @(negedge clk);
        chk("lat_c2_valid", 16'(out_valid), 16'h0000);
        @(negedge clk);
        chk("p100_valid", 16'(out_valid), 16'h0001);
        chk("p100_sum",   16'(out_sum),   16'h0190);
        chk("p100_sat",   16'(out_sat),   16'h0000);
        @(negedge clk);
        chk("p100_pulse", 16'(out_valid), 16'h0000);
        chk("p100_hold",  16'(out_sum),   16'h0190);

        // Positive clamp, negative clamp, full-precision cancellation, back to back.
        drive(all4(10'h1FF), 1'b1, 1'b0, 1'b0);
        drive(all4(10'h200), 1'b1, 1'b0, 1'b0);
        drive({10'h200, 10'h200, 10'h1FF, 10'h1FF}, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        chk("pmax_valid", 16'(out_valid), 16'h0001);
        chk("pmax_sum",   16'(out_sum),   16'h01FF);
        chk("pmax_sat",   16'(out_sat),   16'h0001);
        @(negedge clk);
        chk("nmax_valid", 16'(out_valid), 16'h0001);
        chk("nmax_sum",   16'(out_sum),   16'h0200);
        chk("nmax_sat",   16'(out_sat),   16'h0001);
        @(negedge clk);
        chk("mix_valid", 16'(out_valid), 16'h0001);
        chk("mix_sum",   16'(out_sum),   16'h03FE);
        chk("mix_sat",   16'(out_sat),   16'h0000);

        // Group of three +50 beats: 600 clamps to 511.
        @(negedge clk);
        drive(all4(10'd50), 1'b1, 1'b0, 1'b1);
        drive(all4(10'd50), 1'b1, 1'b0, 1'b1);
        drive(all4(10'd50), 1'b1, 1'b1, 1'b1);
        idle_inputs();
        chk("grp3_b1_quiet", 16'(out_valid), 16'h0000);
        chk("grp3_hold_sum", 16'(out_sum),   16'h03FE);
        @(negedge clk);
        chk("grp3_b2_quiet", 16'(out_valid), 16'h0000);
        @(negedge clk);
        chk("grp3_valid", 16'(out_valid), 16'h0001);
        chk("grp3_sum",   16'(out_sum),   16'h01FF);
        chk("grp3_sat",   16'(out_sat),   16'h0001);

        // Group +100 lanes then -100 lanes: 0, and no leftover clamp flag.
        drive(all4(10'd100), 1'b1, 1'b0, 1'b1);
        drive(all4(10'h39C), 1'b1, 1'b1, 1'b1);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("grp0_valid", 16'(out_valid), 16'h0001);
        chk("grp0_sum",   16'(out_sum),   16'h0000);
        chk("grp0_sat",   16'(out_sat),   16'h0000);
        @(negedge clk);

        // Eight consecutive plain beats, lane value 10*k, expect 40*k in order.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_data  = all4(10'(10 * (i + 1)));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 2) begin
                chk("stream_valid", 16'(out_valid), 16'h0001);
                chk("stream_sum",   16'(out_sum),   16'(40 * (i - 1)));
            end
        end

        // Plain beat injected inside a group: 120 for the beat, then 80+100=180 for the group.
        drive(all4(10'd20), 1'b1, 1'b0, 1'b1);
        drive(all4(10'd30), 1'b1, 1'b0, 1'b0);
        drive(all4(10'd25), 1'b1, 1'b1, 1'b1);
        idle_inputs();
        chk("inj_b1_quiet", 16'(out_valid), 16'h0000);
        @(negedge clk);
        chk("inj_plain_valid", 16'(out_valid), 16'h0001);
        chk("inj_plain_sum",   16'(out_sum),   16'h0078);
        @(negedge clk);
        chk("inj_grp_valid", 16'(out_valid), 16'h0001);
        chk("inj_grp_sum",   16'(out_sum),   16'h00B4);
        chk("inj_grp_sat",   16'(out_sat),   16'h0000);
        @(negedge clk);

        // Open a group, put plain beats in flight, then reset while a result is showing.
        drive(all4(10'd100), 1'b1, 1'b0, 1'b1);
        drive(all4(10'd100), 1'b1, 1'b0, 1'b1);
        drive(all4(10'd1),   1'b1, 1'b0, 1'b0);
        drive(all4(10'd2),   1'b1, 1'b0, 1'b0);
        drive(all4(10'd3),   1'b1, 1'b0, 1'b0);
        idle_inputs();
        chk("pre_rst_valid", 16'(out_valid), 16'h0001);
        chk("pre_rst_sum",   16'(out_sum),   16'h0004);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", 16'(out_valid), 16'h0000);
        chk("async_rst_sum",   16'(out_sum),   16'h0000);
        chk("async_rst_sat",   16'(out_sat),   16'h0000);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 16'(out_valid), 16'h0000);
        end

        // Fresh two-beat group of +10 lanes: 80, with no trace of the abandoned group.
        drive(all4(10'd10), 1'b1, 1'b0, 1'b1);
        drive(all4(10'd10), 1'b1, 1'b1, 1'b1);
        idle_inputs();
        @(negedge clk);
        chk("new_grp_b1_quiet", 16'(out_valid), 16'h0000);
        @(negedge clk);
        chk("new_grp_valid", 16'(out_valid), 16'h0001);
        chk("new_grp_sum",   16'(out_sum),   16'h0050);
        chk("new_grp_sat",   16'(out_sat),   16'h0000);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
